de2_115_qsys_cpu_oci_dct_packer: RTL and testbench

Producer end of the OCI data-capture-trace (DCT) path. It accepts 2-bit trace symbols from the debug capture logic and packs them LSB-first into 30-bit frames of up to 15 symbols. It presents each frame as `dct_buffer`/`dct_count` to the trace consumer over a valid/ready handshake. On an end-of-test request it drains residual data, then signals `test_ending` and `test_has_ended`.

---
 rtl/de2_115_qsys_cpu_oci_dct_pkg.sv | 20 ++
 rtl/de2_115_qsys_cpu_oci_dct_out_reg.sv | 48 ++++
 rtl/de2_115_qsys_cpu_oci_dct_packer.sv | 164 ++++++++++++++++
 tb/tb_de2_115_qsys_cpu_oci_dct_packer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/de2_115_qsys_cpu_oci_dct_pkg.sv
// Shared definitions for the OCI data-capture-trace (DCT) packer.
//   SYM_W    : width of one trace symbol
//   DCT_SYMS : symbols per packed frame
//   DCT_W    : packed frame width (SYM_W * DCT_SYMS)
//   CNT_W    : width of the per-frame symbol count
//   dct_state_e : packer FSM states
package de2_115_qsys_cpu_oci_dct_pkg;

    localparam int SYM_W    = 2;
    localparam int DCT_SYMS = 15;
    localparam int DCT_W    = SYM_W * DCT_SYMS;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ENDED = 2'd2
    } dct_state_e;

endpackage

// File: rtl/de2_115_qsys_cpu_oci_dct_out_reg.sv
// Valid/ready holding register for one packed DCT frame (buffer + count).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   load                : capture load_buf/load_cnt and raise out_valid;
//                         the caller only loads while free is high
//   load_buf, load_cnt  : frame to capture
//   out_ready           : consumer accepts the presented frame
//   out_valid           : a frame is presented
//   out_buf, out_cnt    : presented frame, stable while out_valid && !out_ready
//   free                : register can take a new frame this cycle
//                         (empty, or its frame is being accepted now)
module de2_115_qsys_cpu_oci_dct_out_reg
    import de2_115_qsys_cpu_oci_dct_pkg::*;
#(
    parameter int BUF_W    = DCT_W,
    parameter int CNT_BITS = CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [BUF_W-1:0]    load_buf,
    input  logic [CNT_BITS-1:0] load_cnt,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [BUF_W-1:0]    out_buf,
    output logic [CNT_BITS-1:0] out_cnt,
    output logic                free
);

    assign free = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_buf   <= '0;
            out_cnt   <= '0;
        end else if (load) begin
            // A load in the same cycle as an accept replaces the frame
            // without a bubble.
            out_valid <= 1'b1;
            out_buf   <= load_buf;
            out_cnt   <= load_cnt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/de2_115_qsys_cpu_oci_dct_packer.sv
// Producer end of the OCI DCT path: packs 2-bit trace symbols LSB-first
// into 30-bit frames of up to 15 symbols and hands them to the consumer.
// An end-of-test request drains residual data and then ends the test.
//
// Handshakes: a transfer happens on a rising clk edge where valid and
// ready are both high. Symbol side: sym_valid/sym_ready, the producer
// holds sym_data while sym_valid is high and sym_ready is low. Frame
// side: dct_valid/dct_ready, dct_buffer/dct_count are held stable while
// dct_valid is high and dct_ready is low; dct_valid never depends on
// dct_ready.
//
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   sym_valid, sym_data : symbol offered by the capture logic
//   sym_ready           : symbol accepted when high with sym_valid
//   flush               : pulse, emit the partial frame
//   end_req             : pulse, drain then end the test
//   dct_valid, dct_ready: frame handshake
//   dct_buffer          : packed frame, unused high bits are 0
//   dct_count           : valid symbols in the frame (1..15)
//   test_ending         : one-cycle pulse when the drain completes
//   test_has_ended      : sticky end flag
module de2_115_qsys_cpu_oci_dct_packer #(
    parameter int SYM_W    = de2_115_qsys_cpu_oci_dct_pkg::SYM_W,
    parameter int DCT_SYMS = de2_115_qsys_cpu_oci_dct_pkg::DCT_SYMS,
    parameter int DCT_W    = de2_115_qsys_cpu_oci_dct_pkg::DCT_W
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          sym_valid,
    input  logic [SYM_W-1:0]                              sym_data,
    output logic                                          sym_ready,
    input  logic                                          flush,
    input  logic                                          end_req,
    output logic                                          dct_valid,
    input  logic                                          dct_ready,
    output logic [DCT_W-1:0]                              dct_buffer,
    output logic [de2_115_qsys_cpu_oci_dct_pkg::CNT_W-1:0] dct_count,
    output logic                                          test_ending,
    output logic                                          test_has_ended
);

    import de2_115_qsys_cpu_oci_dct_pkg::*;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DCT_SYMS);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    dct_state_e       state;
    dct_state_e       state_nxt;
    logic [DCT_W-1:0] acc;
    logic [DCT_W-1:0] acc_ins;
    logic [CNT_W-1:0] acc_cnt;
    logic             flush_pend;
    logic             flush_pend_nxt;
    logic             out_free;
    logic             acc_full;
    logic             acc_empty;
    logic             sym_accept;
    logic             transfer;

    assign acc_full   = (acc_cnt == FULL_CNT);
    assign acc_empty  = (acc_cnt == '0);

    // Gated by reset_n so every output reads 0 while reset is held.
    assign sym_ready  = reset_n && (state == RUN) && (!acc_full || out_free);
    assign sym_accept = sym_valid && sym_ready;

    assign transfer = out_free &&
                      (acc_full || (!acc_empty && (flush_pend || state == DRAIN)));

    assign test_has_ended = (state == ENDED);

    // Accumulator with the incoming symbol written into the next free slot.
    always_comb begin
        acc_ins = acc;
        for (int i = 0; i < DCT_SYMS; i++) begin
            if (acc_cnt == CNT_W'(i)) begin
                acc_ins[i*SYM_W +: SYM_W] = sym_data;
            end
        end
    end

    // Flush request survives until it produces a frame; a request that
    // finds the accumulator empty is dropped so no empty frame is emitted.
    always_comb begin
        flush_pend_nxt = flush_pend;
        if (transfer || acc_empty) begin
            flush_pend_nxt = 1'b0;
        end
        if (flush && state == RUN) begin
            flush_pend_nxt = 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        test_ending = 1'b0;
        case (state)
            RUN: begin
                if (end_req) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (acc_empty && !dct_valid) begin
                    state_nxt   = ENDED;
                    test_ending = 1'b1;
                end
            end
            ENDED: begin
                state_nxt = ENDED;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_pend <= flush_pend_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            acc_cnt <= '0;
        end else if (transfer) begin
            // A symbol arriving with the transfer starts the next frame.
            if (sym_accept) begin
                acc     <= DCT_W'(sym_data);
                acc_cnt <= ONE_CNT;
            end else begin
                acc     <= '0;
                acc_cnt <= '0;
            end
        end else if (sym_accept) begin
            acc     <= acc_ins;
            acc_cnt <= acc_cnt + ONE_CNT;
        end
    end

    de2_115_qsys_cpu_oci_dct_out_reg #(
        .BUF_W    (DCT_W),
        .CNT_BITS (CNT_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (reset_n),
        .load      (transfer),
        .load_buf  (acc),
        .load_cnt  (acc_cnt),
        .out_ready (dct_ready),
        .out_valid (dct_valid),
        .out_buf   (dct_buffer),
        .out_cnt   (dct_count),
        .free      (out_free)
    );

endmodule

// File: tb/tb_de2_115_qsys_cpu_oci_dct_packer.sv
// Self-checking bench for de2_115_qsys_cpu_oci_dct_packer.
// Reference model: accepted symbols collect in a queue; a frame is the
// queue contents weighted by powers of four, cut at 15 symbols, at a
// flush or at the end request. Expected frames go to exp_q and a monitor
// compares every frame the DUT hands over.
module tb_de2_115_qsys_cpu_oci_dct_packer;

    localparam int DCT_W = 30;
    localparam int CNT_W = 4;
    localparam int FRM_W = DCT_W + CNT_W;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             sym_valid = 1'b0;
    logic [1:0]       sym_data = 2'b00;
    logic             flush = 1'b0;
    logic             end_req = 1'b0;
    logic             dct_ready = 1'b0;
    logic             sym_ready;
    logic             dct_valid;
    logic [DCT_W-1:0] dct_buffer;
    logic [CNT_W-1:0] dct_count;
    logic             test_ending;
    logic             test_has_ended;

    always #5 clk = ~clk;

    de2_115_qsys_cpu_oci_dct_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sym_valid      (sym_valid),
        .sym_data       (sym_data),
        .sym_ready      (sym_ready),
        .flush          (flush),
        .end_req        (end_req),
        .dct_valid      (dct_valid),
        .dct_ready      (dct_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    // ---------------- scoreboard state ----------------
    int               checks = 0;
    int               errors = 0;
    logic [FRM_W-1:0] exp_q[$];
    logic [1:0]       acc_q[$];
    bit               model_run = 1'b1;
    int               accepts = 0;
    int               ending_pulses = 0;
    int               ready_hi_cnt = 0;
    int               a0;
    int               idx;
    int               vcnt;
    bit               last_acc = 1'b1;
    logic [1:0]       bp_syms[32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [FRM_W-1:0] frame_of_acc();
        longint v = 0;
        longint w = 1;
        foreach (acc_q[i]) begin
            v += longint'(acc_q[i]) * w;
            w *= 4;
        end
        return {CNT_W'(acc_q.size()), DCT_W'(v)};
    endfunction

    task automatic model_emit();
        if (acc_q.size() > 0) begin
            exp_q.push_back(frame_of_acc());
            acc_q.delete();
        end
    endtask

    task automatic model_accept(input logic [1:0] d);
        acc_q.push_back(d);
        accepts++;
        if (acc_q.size() == 15) model_emit();
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge with inputs already set; observes the
    // handshake mid-cycle and returns at the next falling edge.
    task automatic step();
        #1;
        if (sym_valid && sym_ready) model_accept(sym_data);
        if (model_run && flush) model_emit();
        if (model_run && end_req) begin
            model_emit();
            model_run = 1'b0;
        end
        if (test_ending) ending_pulses++;
        if (sym_ready) ready_hi_cnt++;
        @(negedge clk);
    endtask

    task automatic quiet_flush();
        sym_valid = 1'b0;
        dct_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        step();
    endtask

    task automatic wait_drain();
        sym_valid = 1'b0;
        dct_ready = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
        step();
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic send_syms(input int n, input bit rnd, input logic [1:0] d);
        for (int i = 0; i < n; i++) begin
            sym_valid = 1'b1;
            sym_data = rnd ? 2'($urandom_range(0, 3)) : d;
            a0 = accepts;
            step();
            if (accepts == a0) check("send_accept", 0, 1);
        end
        sym_valid = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [FRM_W-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n && dct_valid && dct_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected: got count %0d buffer %0h, expected no frame",
                             dct_count, dct_buffer);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_count", dct_count, e[FRM_W-1:DCT_W]);
                    check("frame_buffer", dct_buffer, e[DCT_W-1:0]);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        check("rst_sym_ready", sym_ready, 0);
        check("rst_dct_valid", dct_valid, 0);
        check("rst_dct_buffer", dct_buffer, 0);
        check("rst_dct_count", dct_count, 0);
        check("rst_test_ending", test_ending, 0);
        check("rst_test_has_ended", test_has_ended, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", sym_ready, 1);

        // Full frame: valid appears one edge after the 15th accept.
        dct_ready = 1'b1;
        send_syms(15, 1'b0, 2'b01);
        check("full_valid_at_n", dct_valid, 0);
        step();
        check("full_valid_at_n1", dct_valid, 1);
        check("full_count", dct_count, 15);
        check("full_buffer", dct_buffer, 30'h15555555);
        step();

        // Partial flush.
        send_syms(3, 1'b0, 2'b11);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_valid_at_n", dct_valid, 0);
        step();
        check("flush_valid_at_n1", dct_valid, 1);
        check("flush_count", dct_count, 3);
        check("flush_buffer", dct_buffer, 30'h0000003F);
        step();

        // Empty flush must not produce a frame.
        flush = 1'b1;
        step();
        flush = 1'b0;
        vcnt = 0;
        repeat (20) begin
            step();
            if (dct_valid) vcnt++;
        end
        check("empty_flush_frames", vcnt, 0);

        // Backpressure: 30-symbol capacity, first frame held.
        foreach (bp_syms[i]) bp_syms[i] = 2'($urandom_range(0, 3));
        dct_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 45; c++) begin
            sym_valid = 1'b1;
            sym_data = bp_syms[idx];
            a0 = accepts;
            step();
            if (accepts != a0) idx++;
            if (c == 20) check("bp_hold_buffer_early", dct_buffer, exp_q[0][DCT_W-1:0]);
        end
        check("bp_accepts", idx, 30);
        check("bp_ready_low", sym_ready, 0);
        check("bp_valid_held", dct_valid, 1);
        check("bp_hold_buffer_late", dct_buffer, exp_q[0][DCT_W-1:0]);
        check("bp_hold_count", dct_count, 15);
        dct_ready = 1'b1;
        for (int c = 0; c < 60 && idx < 32; c++) begin
            sym_data = bp_syms[idx];
            a0 = accepts;
            step();
            if (accepts != a0) idx++;
        end
        check("bp_release_accepts", idx, 32);
        sym_valid = 1'b0;
        quiet_flush();
        wait_drain();

        // Randomised traffic with occasional flushes.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                quiet_flush();
                last_acc = 1'b1;
            end else begin
                if (!sym_valid || last_acc) begin
                    sym_valid = ($urandom_range(0, 3) != 0);
                    sym_data = 2'($urandom_range(0, 3));
                end
                dct_ready = ($urandom_range(0, 3) != 0);
                a0 = accepts;
                step();
                last_acc = (accepts != a0);
            end
        end
        quiet_flush();
        wait_drain();

        // Reset in the middle of a frame discards the partial data.
        dct_ready = 1'b1;
        send_syms(7, 1'b1, 2'b00);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_sym_ready", sym_ready, 0);
        check("midrst_dct_valid", dct_valid, 0);
        check("midrst_dct_buffer", dct_buffer, 0);
        check("midrst_dct_count", dct_count, 0);
        check("midrst_test_ending", test_ending, 0);
        check("midrst_test_has_ended", test_has_ended, 0);
        acc_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_syms(15, 1'b1, 2'b00);
        step();
        check("midrst_clean_valid", dct_valid, 1);
        check("midrst_clean_count", dct_count, 15);
        wait_drain();

        // End sequence with the output stalled.
        send_syms(5, 1'b1, 2'b00);
        dct_ready = 1'b0;
        ending_pulses = 0;
        end_req = 1'b1;
        step();
        end_req = 1'b0;
        ready_hi_cnt = 0;
        repeat (10) begin
            sym_valid = 1'b1;
            sym_data = 2'($urandom_range(0, 3));
            step();
        end
        sym_valid = 1'b0;
        check("drain_sym_ready_cycles", ready_hi_cnt, 0);
        check("drain_valid_held", dct_valid, 1);
        check("drain_count", dct_count, 5);
        check("drain_no_ending_yet", ending_pulses, 0);
        check("drain_not_ended_yet", test_has_ended, 0);
        dct_ready = 1'b1;
        for (int i = 0; i < 20 && ending_pulses == 0; i++) step();
        check("end_pulse_seen", ending_pulses, 1);
        check("end_after_frame", exp_q.size(), 0);
        repeat (10) step();
        check("end_pulse_width", ending_pulses, 1);
        check("end_sticky", test_has_ended, 1);

        // ENDED is terminal.
        ready_hi_cnt = 0;
        vcnt = 0;
        sym_valid = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        end_req = 1'b1;
        step();
        end_req = 1'b0;
        repeat (15) begin
            step();
            if (dct_valid) vcnt++;
        end
        sym_valid = 1'b0;
        check("ended_sym_ready_cycles", ready_hi_cnt, 0);
        check("ended_frames", vcnt, 0);
        check("ended_no_new_pulse", ending_pulses, 1);
        check("ended_still_sticky", test_has_ended, 1);
        check("final_exp_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
